// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register bank.
// Exposes NUM_REGS 32-bit read/write registers. Write address and write data
// are captured independently and commit together. Write and read responses
// are registered. Accesses outside the register window answer SLVERR.
// All outputs come straight from flops, so no input reaches an output
// combinationally.
module axil_slave_regfile #(
   parameter int                        NUM_REGS       = 8,
   parameter int                        AXI_DATA_WIDTH = 32,
   parameter int                        AXI_ADDR_WIDTH = 32,
   parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = {AXI_ADDR_WIDTH{1'b0}}
) (
   input  logic                                    aclk,
   input  logic                                    areset,
   input  logic [AXI_ADDR_WIDTH-1:0]               s_axil_awaddr,
   input  logic                                    s_axil_awvalid,
   output logic                                    s_axil_awready,
   input  logic [AXI_DATA_WIDTH-1:0]               s_axil_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0]             s_axil_wstrb,
   input  logic                                    s_axil_wvalid,
   output logic                                    s_axil_wready,
   output logic [1:0]                              s_axil_bresp,
   output logic                                    s_axil_bvalid,
   input  logic                                    s_axil_bready,
   input  logic [AXI_ADDR_WIDTH-1:0]               s_axil_araddr,
   input  logic                                    s_axil_arvalid,
   output logic                                    s_axil_arready,
   output logic [AXI_DATA_WIDTH-1:0]               s_axil_rdata,
   output logic [1:0]                              s_axil_rresp,
   output logic                                    s_axil_rvalid,
   input  logic                                    s_axil_rready,
   output logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]                     wr_pulse
);

   localparam int STRB_W = AXI_DATA_WIDTH / 8;
   localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [AXI_ADDR_WIDTH-1:0] NUM_REGS_A = AXI_ADDR_WIDTH'(NUM_REGS);
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // An address is inside the window when it is at or above the base and its
   // word offset selects an existing register; the two low bits are ignored.
   function automatic logic addr_legal(input logic [AXI_ADDR_WIDTH-1:0] addr);
      logic [AXI_ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ((off >> 2'd2) < NUM_REGS_A);
   endfunction

   // Register index of an address (only meaningful when addr_legal is true).
   function automatic logic [IDX_W-1:0] addr_idx(input logic [AXI_ADDR_WIDTH-1:0] addr);
      logic [AXI_ADDR_WIDTH-1:0] off;
      off = addr - BASE_ADDR;
      return IDX_W'(off >> 2'd2);
   endfunction

   // State registers
   logic                                    aw_held_r, w_held_r;
   logic [AXI_ADDR_WIDTH-1:0]               aw_addr_r;
   logic [AXI_DATA_WIDTH-1:0]               w_data_r;
   logic [STRB_W-1:0]                       w_strb_r;
   logic                                    awready_r, wready_r, arready_r;
   logic                                    bvalid_r, rvalid_r;
   logic [1:0]                              bresp_r, rresp_r;
   logic [AXI_DATA_WIDTH-1:0]               rdata_r;
   logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_r;
   logic [NUM_REGS-1:0]                     wr_pulse_r;

   // Next-state values
   logic                                    aw_held_s, w_held_s;
   logic [AXI_ADDR_WIDTH-1:0]               aw_addr_s;
   logic [AXI_DATA_WIDTH-1:0]               w_data_s;
   logic [STRB_W-1:0]                       w_strb_s;
   logic                                    awready_s, wready_s, arready_s;
   logic                                    bvalid_s, rvalid_s;
   logic [1:0]                              bresp_s, rresp_s;
   logic [AXI_DATA_WIDTH-1:0]               rdata_s;
   logic [NUM_REGS-1:0][AXI_DATA_WIDTH-1:0] regs_s;
   logic [NUM_REGS-1:0]                     wr_pulse_s;

   // Handshake and commit helpers
   logic                      aw_hs_s, w_hs_s, ar_hs_s, commit_s;
   logic [AXI_ADDR_WIDTH-1:0] wr_addr_s;
   logic [AXI_DATA_WIDTH-1:0] wr_data_s;
   logic [STRB_W-1:0]         wr_strb_s;
   logic                      wr_legal_s, rd_legal_s;
   logic [IDX_W-1:0]          wr_idx_s, rd_idx_s;

   // Handshake detection and selection of the committing address/data.
   always_comb begin
      aw_hs_s    = s_axil_awvalid && awready_r;
      w_hs_s     = s_axil_wvalid && wready_r;
      ar_hs_s    = s_axil_arvalid && arready_r;
      // Commit on the edge where the second half arrives (or both together).
      commit_s   = (aw_hs_s || aw_held_r) && (w_hs_s || w_held_r) && (aw_hs_s || w_hs_s);
      wr_addr_s  = aw_hs_s ? s_axil_awaddr : aw_addr_r;
      wr_data_s  = w_hs_s ? s_axil_wdata : w_data_r;
      wr_strb_s  = w_hs_s ? s_axil_wstrb : w_strb_r;
      wr_legal_s = addr_legal(wr_addr_s);
      wr_idx_s   = addr_idx(wr_addr_s);
      rd_legal_s = addr_legal(s_axil_araddr);
      rd_idx_s   = addr_idx(s_axil_araddr);
   end

   // Write channel: holding flags, capture, commit and response.
   always_comb begin
      aw_held_s  = aw_held_r;
      w_held_s   = w_held_r;
      aw_addr_s  = aw_addr_r;
      w_data_s   = w_data_r;
      w_strb_s   = w_strb_r;
      bvalid_s   = bvalid_r;
      bresp_s    = bresp_r;
      regs_s     = regs_r;
      wr_pulse_s = {NUM_REGS{1'b0}};

      if (commit_s) begin
         aw_held_s = 1'b0;
         w_held_s  = 1'b0;
         bvalid_s  = 1'b1;
         bresp_s   = wr_legal_s ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_hs_s) begin
            aw_held_s = 1'b1;
            aw_addr_s = s_axil_awaddr;
         end else begin
            aw_held_s = aw_held_r;
         end
         if (w_hs_s) begin
            w_held_s = 1'b1;
            w_data_s = s_axil_wdata;
            w_strb_s = s_axil_wstrb;
         end else begin
            w_held_s = w_held_r;
         end
         if (bvalid_r && s_axil_bready) begin
            bvalid_s = 1'b0;
         end else begin
            bvalid_s = bvalid_r;
         end
      end

      // Byte-wise update; the pulse fires even with an all-zero strobe.
      if (commit_s && wr_legal_s) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb_s[b]) begin
               regs_s[wr_idx_s][8*b +: 8] = wr_data_s[8*b +: 8];
            end else begin
               regs_s[wr_idx_s][8*b +: 8] = regs_r[wr_idx_s][8*b +: 8];
            end
         end
         wr_pulse_s[wr_idx_s] = 1'b1;
      end else begin
         wr_pulse_s = {NUM_REGS{1'b0}};
      end

      awready_s = !aw_held_s && !bvalid_s;
      wready_s  = !w_held_s && !bvalid_s;
   end

   // Read channel: registered data/response, reads see the pre-write value.
   always_comb begin
      rvalid_s = rvalid_r;
      rdata_s  = rdata_r;
      rresp_s  = rresp_r;
      if (ar_hs_s) begin
         rvalid_s = 1'b1;
         if (rd_legal_s) begin
            rdata_s = regs_r[rd_idx_s];
            rresp_s = RESP_OKAY;
         end else begin
            rdata_s = {AXI_DATA_WIDTH{1'b0}};
            rresp_s = RESP_SLVERR;
         end
      end else if (rvalid_r && s_axil_rready) begin
         rvalid_s = 1'b0;
      end else begin
         rvalid_s = rvalid_r;
      end
      arready_s = !rvalid_s;
   end

   // State register with synchronous reset; ready flags stay low during reset.
   always_ff @(posedge aclk) begin
      if (areset) begin
         aw_held_r  <= 1'b0;
         w_held_r   <= 1'b0;
         aw_addr_r  <= {AXI_ADDR_WIDTH{1'b0}};
         w_data_r   <= {AXI_DATA_WIDTH{1'b0}};
         w_strb_r   <= {STRB_W{1'b0}};
         awready_r  <= 1'b0;
         wready_r   <= 1'b0;
         arready_r  <= 1'b0;
         bvalid_r   <= 1'b0;
         rvalid_r   <= 1'b0;
         bresp_r    <= 2'b00;
         rresp_r    <= 2'b00;
         rdata_r    <= {AXI_DATA_WIDTH{1'b0}};
         regs_r     <= '0;
         wr_pulse_r <= {NUM_REGS{1'b0}};
      end else begin
         aw_held_r  <= aw_held_s;
         w_held_r   <= w_held_s;
         aw_addr_r  <= aw_addr_s;
         w_data_r   <= w_data_s;
         w_strb_r   <= w_strb_s;
         awready_r  <= awready_s;
         wready_r   <= wready_s;
         arready_r  <= arready_s;
         bvalid_r   <= bvalid_s;
         rvalid_r   <= rvalid_s;
         bresp_r    <= bresp_s;
         rresp_r    <= rresp_s;
         rdata_r    <= rdata_s;
         regs_r     <= regs_s;
         wr_pulse_r <= wr_pulse_s;
      end
   end

   assign s_axil_awready = awready_r;
   assign s_axil_wready  = wready_r;
   assign s_axil_arready = arready_r;
   assign s_axil_bvalid  = bvalid_r;
   assign s_axil_bresp   = bresp_r;
   assign s_axil_rvalid  = rvalid_r;
   assign s_axil_rresp   = rresp_r;
   assign s_axil_rdata   = rdata_r;
   assign reg_out        = regs_r;
   assign wr_pulse       = wr_pulse_r;

endmodule
